// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational RV32I ALU between two requesters. Each request
//   port uses a valid/ready handshake; a round-robin arbiter picks one
//   eligible port, registers its operands into the ALU input registers,
//   lets the ALU evaluate for one cycle (EXEC), and captures result/zero
//   into that port's response slot. Each slot holds its result until the
//   requester takes it with rspN_valid & rspN_ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake, N = 0,1
//   reqN_op1/op2/ctrl          operands and ALU control of requester N
//   rspN_valid/ready           response handshake, N = 0,1
//   rspN_result/zero           captured ALU result and zero flag
//   alu_op1/op2/ctrl           registered drive to the shared ALU
//   alu_result/zero            combinational return from the shared ALU
//   busy                       high while the ALU is evaluating (EXEC)
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int CTRLW = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_op1,
   input  logic [WIDTH-1:0] req0_op2,
   input  logic [CTRLW-1:0] req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_op1,
   input  logic [WIDTH-1:0] req1_op2,
   input  logic [CTRLW-1:0] req1_ctrl,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   output logic [WIDTH-1:0] alu_op1,
   output logic [WIDTH-1:0] alu_op2,
   output logic [CTRLW-1:0] alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             grant_q, grant_d;
   logic [WIDTH-1:0] alu_op1_q, alu_op1_d;
   logic [WIDTH-1:0] alu_op2_q, alu_op2_d;
   logic [CTRLW-1:0] alu_ctrl_q, alu_ctrl_d;
   logic [1:0]       rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_q [2];
   logic [WIDTH-1:0] rsp_result_d [2];
   logic [1:0]       rsp_zero_q, rsp_zero_d;

   // Per-port views of the request/response ports so the arbiter can index them.
   logic [1:0]       req_valid;
   logic [1:0]       rsp_ready;
   logic [1:0]       req_ready;
   logic [1:0]       eligible;
   logic             grant_sel;
   logic [WIDTH-1:0] req_op1  [2];
   logic [WIDTH-1:0] req_op2  [2];
   logic [CTRLW-1:0] req_ctrl [2];

   assign req_valid   = {req1_valid, req0_valid};
   assign rsp_ready   = {rsp1_ready, rsp0_ready};
   assign req_op1[0]  = req0_op1;
   assign req_op1[1]  = req1_op1;
   assign req_op2[0]  = req0_op2;
   assign req_op2[1]  = req1_op2;
   assign req_ctrl[0] = req0_ctrl;
   assign req_ctrl[1] = req1_ctrl;

   // A port whose slot is still occupied cannot issue, even if that slot is
   // being drained this very cycle; this keeps ready independent of rsp_ready.
   assign eligible = req_valid & ~rsp_valid_q;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      alu_op1_d    = alu_op1_q;
      alu_op2_d    = alu_op2_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      req_ready    = 2'b00;
      grant_sel    = ~last_grant_q;

      // Slots drain independently of the arbiter state.
      rsp_valid_d  = rsp_valid_q & ~rsp_ready;

      case (state_q)
         IDLE: begin
            if (|eligible) begin
               // Both eligible: the port that did not win last time.
               // One eligible: eligible[1] is exactly the index of that port.
               grant_sel            = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
               req_ready[grant_sel] = 1'b1;
               alu_op1_d            = req_op1[grant_sel];
               alu_op2_d            = req_op2[grant_sel];
               alu_ctrl_d           = req_ctrl[grant_sel];
               grant_d              = grant_sel;
               last_grant_d         = grant_sel;
               state_d              = EXEC;
            end
         end
         EXEC: begin
            // The granted slot was empty at grant time, so no drain can collide.
            rsp_valid_d[grant_q]  = 1'b1;
            rsp_result_d[grant_q] = alu_result;
            rsp_zero_d[grant_q]   = alu_zero;
            state_d               = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         last_grant_q    <= 1'b1;   // port 0 wins the first contest
         grant_q         <= 1'b0;
         alu_op1_q       <= '0;
         alu_op2_q       <= '0;
         alu_ctrl_q      <= '0;
         rsp_valid_q     <= 2'b00;
         rsp_result_q[0] <= '0;
         rsp_result_q[1] <= '0;
         rsp_zero_q      <= 2'b00;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         grant_q         <= grant_d;
         alu_op1_q       <= alu_op1_d;
         alu_op2_q       <= alu_op2_d;
         alu_ctrl_q      <= alu_ctrl_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_result_q[0] <= rsp_result_d[0];
         rsp_result_q[1] <= rsp_result_d[1];
         rsp_zero_q      <= rsp_zero_d;
      end
   end

   assign req0_ready  = req_ready[0];
   assign req1_ready  = req_ready[1];
   assign rsp0_valid  = rsp_valid_q[0];
   assign rsp1_valid  = rsp_valid_q[1];
   assign rsp0_result = rsp_result_q[0];
   assign rsp1_result = rsp_result_q[1];
   assign rsp0_zero   = rsp_zero_q[0];
   assign rsp1_zero   = rsp_zero_q[1];
   assign alu_op1     = alu_op1_q;
   assign alu_op2     = alu_op2_q;
   assign alu_ctrl    = alu_ctrl_q;
   assign busy        = (state_q == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Bench for alu_arbiter. A behavioural ALU drives alu_result/alu_zero from
//   the DUT's registered operands. A reference model decides each cycle which
//   port should be granted, pushes the expected response into a per-port
//   queue, and a monitor pops and compares whenever a response is consumed.
//   Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [2:0]  req0_ctrl, req1_ctrl;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_zero, rsp1_zero;
   logic [31:0] alu_op1, alu_op2, alu_result;
   logic [2:0]  alu_ctrl;
   logic        alu_zero;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit [1:0]    m_full;
   bit          m_exec;
   int          m_port;
   int          m_last;
   logic [32:0] q0 [$];
   logic [32:0] q1 [$];
   bit [1:0]    mdl_e;
   bit [1:0]    mdl_rdy;
   int          mdl_g;
   logic [32:0] mdl_exp;
   logic [32:0] mon_exp;

   alu_arbiter #(.WIDTH(32), .CTRLW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy)
   );

   // RV32I ALU behaviour, func3 encoding
   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
      case (c)
         3'd0:    return a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   assign alu_result = alu_ref(alu_op1, alu_op2, alu_ctrl);
   assign alu_zero   = (alu_result == 32'd0);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int p, input bit v, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] c);
      if (p == 0) begin
         req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctrl = c;
      end else begin
         req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctrl = c;
      end
   endtask

   function automatic bit rdy(input int p);
      return (p == 0) ? req0_ready : req1_ready;
   endfunction

   task automatic rand_req(input int p);
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(3) == 0) ? a : 32'($urandom);
      set_req(p, 1'b1, a, b, 3'($urandom_range(7)));
   endtask

   // Reset: model and DUT outputs are checked while rst_n is still low.
   task automatic do_reset();
      rst_n = 1'b0;
      set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
      set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      m_full = 2'b00; m_exec = 1'b0; m_port = 0; m_last = 1;
      q0.delete(); q1.delete();
      #1;
      check("rst_busy",       64'(busy),        64'(0));
      check("rst_rsp0_valid", 64'(rsp0_valid),  64'(0));
      check("rst_rsp1_valid", 64'(rsp1_valid),  64'(0));
      check("rst_rsp0_res",   64'(rsp0_result), 64'(0));
      check("rst_rsp1_zero",  64'(rsp1_zero),   64'(0));
      check("rst_alu_op1",    64'(alu_op1),     64'(0));
      check("rst_alu_ctrl",   64'(alu_ctrl),    64'(0));
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
   endtask

   // Present an op and hold it until ready; returns just after the latching edge.
   task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input string name);
      bit got = 1'b0;
      @(posedge clk); #1;
      set_req(p, 1'b1, a, b, c);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = rdy(p);
      end
      check(name, 64'(got), 64'(1));
      @(posedge clk); #1;
      set_req(p, 1'b0, 32'd0, 32'd0, 3'd0);
   endtask

   // Wait for a response right after issue(); checks latency and value.
   task automatic wait_rsp(input int p, input logic [31:0] er, input bit ez, input string name);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         got = (p == 0) ? rsp0_valid : rsp1_valid;
      end
      check({name, "_latency"}, 64'(n), 64'(2));
      check({name, "_result"}, 64'((p == 0) ? rsp0_result : rsp1_result), 64'(er));
      check({name, "_zero"},   64'((p == 0) ? rsp0_zero : rsp1_zero),     64'(ez));
   endtask

   // Reference model: which port should be granted now, and the expected
   // occupancy of the slots and ALU in the next cycle.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         mdl_rdy = 2'b00;
         mdl_g   = -1;
         mdl_e   = 2'b00;
         if (!m_exec) begin
            mdl_e[0] = req0_valid && !m_full[0];
            mdl_e[1] = req1_valid && !m_full[1];
            if (mdl_e == 2'b11) mdl_g = (m_last == 1) ? 0 : 1;
            else if (mdl_e[0])  mdl_g = 0;
            else if (mdl_e[1])  mdl_g = 1;
         end
         if (mdl_g >= 0) mdl_rdy[mdl_g] = 1'b1;
         check("req0_ready", 64'(req0_ready), 64'(mdl_rdy[0]));
         check("req1_ready", 64'(req1_ready), 64'(mdl_rdy[1]));
         check("busy",       64'(busy),       64'(m_exec));
         check("rsp0_valid", 64'(rsp0_valid), 64'(m_full[0]));
         check("rsp1_valid", 64'(rsp1_valid), 64'(m_full[1]));
         if (m_full[0] && rsp0_ready) m_full[0] = 1'b0;
         if (m_full[1] && rsp1_ready) m_full[1] = 1'b0;
         if (m_exec) begin
            m_full[m_port] = 1'b1;
            m_exec = 1'b0;
         end else if (mdl_g >= 0) begin
            if (mdl_g == 0) begin
               mdl_exp[31:0] = alu_ref(req0_op1, req0_op2, req0_ctrl);
               mdl_exp[32]   = (mdl_exp[31:0] == 32'd0);
               q0.push_back(mdl_exp);
            end else begin
               mdl_exp[31:0] = alu_ref(req1_op1, req1_op2, req1_ctrl);
               mdl_exp[32]   = (mdl_exp[31:0] == 32'd0);
               q1.push_back(mdl_exp);
            end
            m_exec = 1'b1;
            m_port = mdl_g;
            m_last = mdl_g;
         end
      end
   end

   // Monitor: compare every consumed response with the scoreboard.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (rsp0_valid && rsp0_ready) begin
            $display("[TB] rsp0 result=%08h zero=%0d", rsp0_result, rsp0_zero);
            check("rsp0_expected", 64'(q0.size() != 0), 64'(1));
            if (q0.size() != 0) begin
               mon_exp = q0.pop_front();
               check("rsp0_result", 64'(rsp0_result), 64'(mon_exp[31:0]));
               check("rsp0_zero",   64'(rsp0_zero),   64'(mon_exp[32]));
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            $display("[TB] rsp1 result=%08h zero=%0d", rsp1_result, rsp1_zero);
            check("rsp1_expected", 64'(q1.size() != 0), 64'(1));
            if (q1.size() != 0) begin
               mon_exp = q1.pop_front();
               check("rsp1_result", 64'(rsp1_result), 64'(mon_exp[31:0]));
               check("rsp1_zero",   64'(rsp1_zero),   64'(mon_exp[32]));
            end
         end
      end
   end

   initial begin
      int order [$];
      int idx0, idx1;
      bit a0, a1, got;

      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;

      // Single-port ALU operations with known answers
      issue(0, 32'd5, 32'd7, 3'b000, "add_accept");
      wait_rsp(0, 32'd12, 1'b0, "add");
      issue(0, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b100, "xor_accept");
      wait_rsp(0, 32'd0, 1'b1, "xor_zero");
      issue(0, 32'hFFFFFFFF, 32'd1, 3'b010, "slt_accept");
      wait_rsp(0, 32'd1, 1'b0, "slt");
      issue(0, 32'hFFFFFFFF, 32'd1, 3'b011, "sltu_accept");
      wait_rsp(0, 32'd0, 1'b1, "sltu");

      // Both ports contend from reset: grants must alternate 0,1,0,1...
      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      @(posedge clk); #1;
      rand_req(0);
      rand_req(1);
      idx0 = 0; idx1 = 0;
      for (int c = 0; c < 60 && (idx0 < 4 || idx1 < 4); c++) begin
         @(negedge clk);
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         if (a0) order.push_back(0);
         if (a1) order.push_back(1);
         @(posedge clk); #1;
         if (a0) begin
            idx0++;
            if (idx0 < 4) rand_req(0); else set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
         end
         if (a1) begin
            idx1++;
            if (idx1 < 4) rand_req(1); else set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
         end
      end
      check("order_len", 64'(order.size()), 64'(8));
      foreach (order[i]) check("grant_order", 64'(order[i]), 64'(i % 2));

      // Backpressure on slot 0 blocks port 0 but not port 1
      repeat (3) @(negedge clk);
      rsp0_ready = 1'b0;
      issue(0, 32'h10, 32'h3, 3'b001, "bp_first_accept");
      wait_rsp(0, 32'h80, 1'b0, "bp_first");
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd1, 32'd2, 3'b000);
      set_req(1, 1'b1, 32'd9, 32'd4, 3'b110);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         check("bp_req0_blocked", 64'(req0_ready), 64'(0));
         got = req1_ready;
      end
      check("bp_req1_accept", 64'(got), 64'(1));
      @(posedge clk); #1;
      set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_rsp(1, 32'hD, 1'b0, "bp_port1");
      repeat (3) begin
         @(negedge clk);
         check("bp_req0_still_blocked", 64'(req0_ready), 64'(0));
      end
      @(posedge clk); #1;
      rsp0_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = req0_ready;
      end
      check("bp_req0_accept", 64'(got), 64'(1));
      @(posedge clk); #1;
      set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_rsp(0, 32'd3, 1'b0, "bp_port0");

      // Reset while the ALU is evaluating; afterwards port 0 wins first
      issue(0, 32'h1234, 32'd1, 3'b000, "rx_accept");
      #2;
      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd100, 32'd23, 3'b000);
      set_req(1, 1'b1, 32'd7, 32'd7, 3'b100);
      @(negedge clk);
      check("rx_first_grant0", 64'(req0_ready), 64'(1));
      check("rx_first_grant1", 64'(req1_ready), 64'(0));
      @(posedge clk); #1;
      set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_rsp(0, 32'd123, 1'b0, "rx_fresh");
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = req1_ready;
      end
      check("rx_port1_accept", 64'(got), 64'(1));
      @(posedge clk); #1;
      set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
      repeat (4) @(negedge clk);

      // Port 1 valid pulsed only during EXEC: never accepted
      issue(0, 32'hF0, 32'h0F, 3'b110, "wd_accept");
      set_req(1, 1'b1, 32'd3, 32'd4, 3'b000);
      @(negedge clk);
      check("wd_req1_ready", 64'(req1_ready), 64'(0));
      @(posedge clk); #1;
      set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
      repeat (6) begin
         @(negedge clk);
         check("wd_rsp1_valid", 64'(rsp1_valid), 64'(0));
      end

      // Randomized traffic with random backpressure and withdrawals
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         @(posedge clk); #1;
         if (!req0_valid || a0) begin
            if ($urandom_range(3) != 0) rand_req(0); else set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
         end else if ($urandom_range(15) == 0) begin
            set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
         end
         if (!req1_valid || a1) begin
            if ($urandom_range(3) != 0) rand_req(1); else set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
         end else if ($urandom_range(15) == 0) begin
            set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
         end
         rsp0_ready = ($urandom_range(9) < 7);
         rsp1_ready = ($urandom_range(9) < 7);
      end

      // Drain everything and make sure nothing expected is left over
      @(posedge clk); #1;
      set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
      set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      repeat (8) @(negedge clk);
      check("drain_q0", 64'(q0.size()), 64'(0));
      check("drain_q1", 64'(q1.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
